// File: rtl/ft6_pkg.sv
// Shared constants, packer state encoding and the byte-to-word pack helper
// for the FT6 sample packer.
package ft6_pkg;

    localparam int FT6_WORD_W = 32;
    localparam int FT6_BYTE_W = 8;
    localparam int FT6_LANES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DROP = 2'd2
    } ft6_state_e;

    // Little-endian assembly: the three earlier bytes sit in the low lanes,
    // the byte completing the word lands in the top lane.
    function automatic logic [FT6_WORD_W-1:0] ft6_pack_word(
        input logic [FT6_WORD_W-FT6_BYTE_W-1:0] low_bytes,
        input logic [FT6_BYTE_W-1:0]            top_byte
    );
        return {top_byte, low_bytes};
    endfunction

endpackage

// File: rtl/ft6_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/level.
// A push while full is accepted only when a pop happens in the same cycle.
module ft6_sync_fifo #(
    parameter int DEPTH  = 32,
    parameter int LVL_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    import ft6_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LVL_W-1:0]  count_r;
    logic              full_s;
    logic              empty_s;
    logic              pop_ok_s;
    logic              push_ok_s;

    assign full_s    = (count_r == LVL_W'(DEPTH));
    assign empty_s   = (count_r == {LVL_W{1'b0}});
    assign pop_ok_s  = pop && !empty_s;
    assign push_ok_s = push && (!full_s || pop_ok_s);

    assign full     = full_s;
    assign empty    = empty_s;
    assign level    = count_r;
    // Head is masked to zero when empty so nothing stale is ever visible.
    assign pop_data = empty_s ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];

    // Storage array write; contents are don't-care until pointed at by a valid entry.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + LVL_W'(1);
                2'b01:   count_r <= count_r - LVL_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ft6_sample_packer.sv
// FT6 sample packer: collects ADC bytes into little-endian 32-bit words and
// queues them for the FT6 write stage. Words that find the queue full are
// dropped (sticky overflow) and capture pauses until the queue is half empty.
// Optional build macro FT6_TESTPAT_EN replaces the ADC byte with an 8-bit
// incrementing test pattern whenever test_mode is high.
module ft6_sample_packer #(
    parameter int FIFO_DEPTH = 32,
    parameter int LVL_W      = 6
) (
    input  logic             ft6_clk,
    input  logic             ft6_rst,
    input  logic             enable,
    input  logic [7:0]       adc_data,
    input  logic             adc_valid,
    input  logic             test_mode,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    input  logic             overflow_clr
);
    import ft6_pkg::*;

    localparam logic [LVL_W-1:0] HALF_LVL = LVL_W'(FIFO_DEPTH / 2);
    localparam logic [1:0]       LAST_IDX = 2'(FT6_LANES - 1);

    ft6_state_e  state_r;
    ft6_state_e  state_nxt_s;
    logic [1:0]  byte_idx_r;
    logic [1:0]  byte_idx_nxt_s;
    logic [23:0] word_r;
    logic [23:0] word_nxt_s;
    logic [31:0] complete_word_s;
    logic [7:0]  sample_s;
    logic        accept_s;
    logic        push_s;
    logic        drop_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    logic [LVL_W-1:0] level_s;
    logic        overflow_r;

    assign accept_s = (state_r == ST_RUN) && enable && adc_valid;
    assign pop_s    = !empty_s && out_ready;

`ifdef FT6_TESTPAT_EN
    logic [7:0] test_cnt_r;

    // Test-pattern counter advances once per byte actually taken in test mode.
    always_ff @(posedge ft6_clk) begin
        if (ft6_rst) begin
            test_cnt_r <= 8'd0;
        end else if (accept_s && test_mode) begin
            test_cnt_r <= test_cnt_r + 8'd1;
        end else begin
            test_cnt_r <= test_cnt_r;
        end
    end

    assign sample_s = test_mode ? test_cnt_r : adc_data;
`else
    logic unused_test_mode_s;
    assign unused_test_mode_s = test_mode;
    assign sample_s = adc_data;
`endif

    assign complete_word_s = ft6_pack_word(word_r, sample_s);

    // Next-state, byte lane assembly and push/drop decisions.
    always_comb begin
        state_nxt_s    = state_r;
        byte_idx_nxt_s = byte_idx_r;
        word_nxt_s     = word_r;
        push_s         = 1'b0;
        drop_s         = 1'b0;
        if (!enable) begin
            state_nxt_s    = ST_IDLE;
            byte_idx_nxt_s = 2'd0;
            word_nxt_s     = 24'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s    = ST_RUN;
                    byte_idx_nxt_s = 2'd0;
                    word_nxt_s     = 24'd0;
                end
                ST_RUN: begin
                    if (adc_valid) begin
                        if (byte_idx_r == LAST_IDX) begin
                            byte_idx_nxt_s = 2'd0;
                            word_nxt_s     = 24'd0;
                            if (!full_s || pop_s) begin
                                push_s = 1'b1;
                            end else begin
                                drop_s      = 1'b1;
                                state_nxt_s = ST_DROP;
                            end
                        end else begin
                            byte_idx_nxt_s = byte_idx_r + 2'd1;
                            case (byte_idx_r)
                                2'd0:    word_nxt_s[7:0]   = sample_s;
                                2'd1:    word_nxt_s[15:8]  = sample_s;
                                2'd2:    word_nxt_s[23:16] = sample_s;
                                default: word_nxt_s        = word_r;
                            endcase
                        end
                    end else begin
                        byte_idx_nxt_s = byte_idx_r;
                    end
                end
                ST_DROP: begin
                    if (level_s <= HALF_LVL) begin
                        state_nxt_s    = ST_RUN;
                        byte_idx_nxt_s = 2'd0;
                        word_nxt_s     = 24'd0;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    byte_idx_nxt_s = 2'd0;
                    word_nxt_s     = 24'd0;
                end
            endcase
        end
    end

    // Packer state, byte index and partial-word registers.
    always_ff @(posedge ft6_clk) begin
        if (ft6_rst) begin
            state_r    <= ST_IDLE;
            byte_idx_r <= 2'd0;
            word_r     <= 24'd0;
        end else begin
            state_r    <= state_nxt_s;
            byte_idx_r <= byte_idx_nxt_s;
            word_r     <= word_nxt_s;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge ft6_clk) begin
        if (ft6_rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    ft6_sync_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .LVL_W  (LVL_W),
        .DATA_W (FT6_WORD_W)
    ) u_fifo (
        .clk       (ft6_clk),
        .rst       (ft6_rst),
        .push      (push_s),
        .push_data (complete_word_s),
        .pop       (pop_s),
        .pop_data  (out_data),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level_s)
    );

    assign out_valid  = !empty_s;
    assign fifo_level = level_s;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_ft6_sample_packer.sv
// Self-checking bench for ft6_sample_packer: a queue-based model of the
// packer is compared against the DUT every cycle, plus directed scenarios
// with hand-computed literal expectations.
module tb_ft6_sample_packer;

    localparam int DEPTH = 32;
    localparam int LW    = 6;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DROP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [7:0]    adc_data;
    logic          adc_valid;
    logic          test_mode;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          overflow_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ft6_sample_packer #(.FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
        .ft6_clk      (clk),
        .ft6_rst      (rst),
        .enable       (enable),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .test_mode    (test_mode),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] mq[$];
    logic [7:0]  mb[$];
    int          mmode;
    bit          movf;
    logic [7:0]  mtcnt;
    bit          model_live = 1'b0;
    bit          m_pop, m_push, m_drop;
    logic [7:0]  m_byte;
    logic [31:0] m_word;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mb.delete();
            mmode = M_IDLE;
            movf  = 1'b0;
            mtcnt = 8'd0;
        end else begin
            m_pop  = (mq.size() > 0) && out_ready;
            m_push = 1'b0;
            m_drop = 1'b0;
            if (!enable) begin
                mmode = M_IDLE;
                mb.delete();
            end else if (mmode == M_IDLE) begin
                mmode = M_RUN;
            end else if (mmode == M_RUN) begin
                if (adc_valid) begin
                    m_byte = adc_data;
`ifdef FT6_TESTPAT_EN
                    if (test_mode) begin
                        m_byte = mtcnt;
                        mtcnt  = mtcnt + 8'd1;
                    end
`endif
                    mb.push_back(m_byte);
                    if (mb.size() == 4) begin
                        m_word = {mb[3], mb[2], mb[1], mb[0]};
                        mb.delete();
                        if (mq.size() < DEPTH || m_pop) m_push = 1'b1;
                        else begin
                            m_drop = 1'b1;
                            mmode  = M_DROP;
                        end
                    end
                end
            end else begin
                if (mq.size() <= DEPTH / 2) mmode = M_RUN;
            end
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(m_word);
            if (m_drop) movf = 1'b1;
            else if (overflow_clr) movf = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_live) begin
            check("model out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("model out_data", out_data, (mq.size() != 0) ? mq[0] : 32'h0);
            check("model fifo_level", 32'(fifo_level), 32'(mq.size()));
            check("model overflow", 32'(overflow), 32'(movf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit r, input bit e, input bit v, input logic [7:0] d,
                       input bit rdy, input bit clr);
        rst = r; enable = e; adc_valid = v; adc_data = d;
        out_ready = rdy; overflow_clr = clr;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b1, w[8*k +: 8], rdy, 1'b0);
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    initial begin
        test_mode = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        model_live = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'h0);
        check("reset fifo_level", 32'(fifo_level), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);

        // Basic packing and latency.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        check("pack pre out_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        check("pack out_data", out_data, 32'h44332211);
        check("pack out_valid", 32'(out_valid), 32'd1);
        check("pack fifo_level", 32'(fifo_level), 32'd1);
        idle_cycles(1, 1'b1);
        check("pack drained", 32'(fifo_level), 32'd0);

        // Enable drop mid-word discards the partial bytes.
        cyc(1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        send_word(32'hA3A2A1A0, 1'b0);
        check("enable-drop out_data", out_data, 32'hA3A2A1A0);
        check("enable-drop fifo_level", 32'(fifo_level), 32'd1);
        idle_cycles(1, 1'b1);

`ifndef FT6_TESTPAT_EN
        // test_mode has no effect without the test-pattern build.
        test_mode = 1'b1;
        send_word(32'hC4C3C2C1, 1'b0);
        test_mode = 1'b0;
        check("test_mode ignored", out_data, 32'hC4C3C2C1);
        idle_cycles(1, 1'b1);
`endif

        // Overflow into DROP, then recovery at half level.
        for (int i = 0; i < 33; i++) send_word(32'h01010101 * (i + 1), 1'b0);
        check("ovf fifo_level", 32'(fifo_level), 32'd32);
        check("ovf overflow", 32'(overflow), 32'd1);
        send_word(32'hF3F2F1F0, 1'b0);
        check("drop discards", 32'(fifo_level), 32'd32);
        idle_cycles(16, 1'b1);
        check("drain16 level", 32'(fifo_level), 32'd16);
        idle_cycles(1, 1'b0);
        send_word(32'hB3B2B1B0, 1'b0);
        check("resume level", 32'(fifo_level), 32'd17);
        idle_cycles(16, 1'b1);
        check("resume word", out_data, 32'hB3B2B1B0);
        idle_cycles(1, 1'b1);
        check("resume empty", 32'(fifo_level), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf clear", 32'(overflow), 32'd0);

        // Full FIFO: push with simultaneous pop is not a drop.
        for (int i = 0; i < 32; i++) send_word(32'h10203040 + i, 1'b0);
        check("full level", 32'(fifo_level), 32'd32);
        cyc(1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0);
        check("push+pop level", 32'(fifo_level), 32'd32);
        check("push+pop overflow", 32'(overflow), 32'd0);
        check("push+pop head", out_data, 32'h10203041);
        // Drop coinciding with clear keeps overflow set.
        cyc(1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h06, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 1'b1);
        check("drop wins clear", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("clear after drop", 32'(overflow), 32'd0);
        idle_cycles(33, 1'b1);
        check("full drained", 32'(fifo_level), 32'd0);

        // Reset mid-word with stored words.
        for (int i = 0; i < 3; i++) send_word(32'hCAFE0000 + i, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h91, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h92, 1'b0, 1'b0);
        check("pre-reset level", 32'(fifo_level), 32'd3);
        cyc(1'b1, 1'b1, 1'b1, 8'h93, 1'b1, 1'b0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'h0);
        check("rst fifo_level", 32'(fifo_level), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h61, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h62, 1'b0, 1'b0);
        check("no stale word", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 8'h63, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 8'h64, 1'b0, 1'b0);
        check("post-reset word", out_data, 32'h64636261);
        idle_cycles(1, 1'b1);

`ifdef FT6_TESTPAT_EN
        // Test-pattern source after a fresh reset.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        test_mode = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        send_word(32'hFFFFFFFF, 1'b0);
        check("testpat word0", out_data, 32'h03020100);
        send_word(32'hFFFFFFFF, 1'b0);
        check("testpat level", 32'(fifo_level), 32'd2);
        idle_cycles(1, 1'b1);
        check("testpat word1", out_data, 32'h07060504);
        test_mode = 1'b0;
        idle_cycles(1, 1'b1);
`endif

        model_live = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft6_sample_packer.md
FT6_SAMPLE_PACKER -- requirements
Module: ft6_sample_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, meaning output word FIFO depth in 32-bit words (power of two, 4..256).
REQ-002 SHALL have parameter LVL_W, default 6, meaning fifo_level width (log2(FIFO_DEPTH)+1).
REQ-003 SHALL have port ft6_clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port ft6_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  capture enable; low discards input.
REQ-006 SHALL have port adc_data  input  8  ADC sample byte.
REQ-007 SHALL have port adc_valid  input  1  adc_data valid this cycle; no backpressure to source.
REQ-008 SHALL have port test_mode  input  1  select internal test-pattern source (see Configuration).
REQ-009 SHALL have port out_data  output  32  packed word to the FT6 write stage.
REQ-010 SHALL have port out_valid  output  1  out_data holds a word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 SHALL have port fifo_level  output  LVL_W  words currently stored.
REQ-013 SHALL have port overflow  output  1  sticky: at least one word dropped.
REQ-014 SHALL have port overflow_clr  input  1  clears overflow.

Function
REQ-015 SHALL accept one byte per cycle when enable && adc_valid in state RUN.
REQ-016 SHALL pack little-endian: first byte -> out_data[7:0], fourth byte -> out_data[31:24].
REQ-017 SHALL write the word into the FIFO on the edge that samples the fourth byte; out_valid SHALL rise the following cycle (1-cycle latency).
REQ-018 SHALL present FIFO head on out_data whenever out_valid=1, first-word fall-through; a transfer occurs iff out_valid && out_ready.
REQ-019 SHALL permit a push when FIFO is full only if a transfer pops in the same cycle; fifo_level then remains unchanged.
REQ-020 SHALL implement states IDLE, RUN, DROP.
REQ-021 IDLE -> RUN when enable=1; RUN -> IDLE when enable=0; any -> IDLE on enable=0.
REQ-022 On entering IDLE, partially packed bytes SHALL be discarded and byte index cleared to 0; FIFO contents SHALL be retained and remain drainable.
REQ-023 In RUN, a completed word with FIFO full and no simultaneous pop SHALL be dropped, overflow set, state -> DROP.
REQ-024 In DROP, all input bytes SHALL be discarded; DROP -> RUN (byte index 0) when fifo_level <= FIFO_DEPTH/2.
REQ-025 overflow_clr SHALL clear overflow; a simultaneous new drop SHALL win (overflow stays 1).
REQ-026 fifo_level SHALL wrap-free saturate semantics: never exceed FIFO_DEPTH, never below 0; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 ft6_rst SHALL force: state IDLE, byte index 0, FIFO empty, out_valid 0, fifo_level 0, overflow 0, out_data 0, test counter 0.
REQ-028 Reset mid-word or mid-transfer SHALL discard all buffered data with no partial word emitted.

Configuration
REQ-029 Macro FT6_TESTPAT_EN SHALL compile in an 8-bit test-pattern counter.
REQ-030 With FT6_TESTPAT_EN and test_mode=1, each accepted byte SHALL be the counter value, counter incrementing by 1 per accepted byte, wrapping 255->0; adc_valid still qualifies acceptance.
REQ-031 Without FT6_TESTPAT_EN, test_mode SHALL be ignored and no counter logic synthesized.

Structure
REQ-032 Package ft6_pkg SHALL hold FT6_WORD_W=32, FT6_BYTE_W=8, FT6_LANES=4 and the packer state enum.
REQ-033 FIFO storage SHALL be a sub-module ft6_sync_fifo (single clock, FWFT, full/empty/level).

Verification
REQ-034 Bytes 0x11,0x22,0x33,0x44 consecutive -> out_data=0x44332211, out_valid one cycle after 4th byte, fifo_level=1.
REQ-035 enable drops after 2 bytes, then bytes 0xA0..0xA3 -> only word 0xA3A2A1A0 emitted.
REQ-036 FIFO_DEPTH=32, out_ready=0, 33 words -> fifo_level=32, overflow=1, DROP; drain 16 -> RUN resumes at byte index 0.
REQ-037 FIFO full, 4th byte and out_ready=1 same cycle -> no drop, level stays 32, overflow stays 0.
REQ-038 ft6_rst asserted after 2 bytes and 3 stored words -> all outputs at reset values next cycle, no stale word emitted.
REQ-039 FT6_TESTPAT_EN, test_mode=1, 8 valid cycles -> words 0x03020100 then 0x07060504.
